// File: rtl/and_gate_exhaustive_checker_if.sv
// =============================================================================
// Module  : and_gate_exhaustive_checker_if
// Purpose : Control, result and DUT-facing stimulus/response signals of the
//           exhaustive AND-gate checker.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

interface and_gate_exhaustive_checker_if #(
    parameter int N_IN  = 3,
    parameter int ERR_W = 8
);
    logic              start;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_IN-1:0]   dut_in;
    logic              dut_y;
    logic [ERR_W-1:0]  err_cnt;
    logic              first_fail_valid;
    logic [N_IN-1:0]   first_fail_vec;

    // Checker side
    modport master (
        input  start,
        input  dut_y,
        output busy,
        output done,
        output pass,
        output dut_in,
        output err_cnt,
        output first_fail_valid,
        output first_fail_vec
    );

    // Controller / DUT side
    modport slave (
        output start,
        output dut_y,
        input  busy,
        input  done,
        input  pass,
        input  dut_in,
        input  err_cnt,
        input  first_fail_valid,
        input  first_fail_vec
    );
endinterface

`default_nettype wire

// File: rtl/and_gate_exhaustive_checker.sv
// =============================================================================
// Module  : and_gate_exhaustive_checker
// Purpose : Sweeps every input vector into an N-input AND gate and checks Y.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module and_gate_exhaustive_checker #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 8
) (
    input  wire logic clk,
    input  wire logic rst_n,
    and_gate_exhaustive_checker_if.master bus
);
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SETTLE_WAIT = 2'd1,
        CHECK       = 2'd2,
        FINISH      = 2'd3
    } state_t;

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(SETTLE - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_IN-1:0]   dut_in_q, dut_in_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              ffv_q, ffv_d;
    logic [N_IN-1:0]   ffvec_q, ffvec_d;
    logic              mismatch;

    // dut_in_q doubles as the sweep vector; it is only non-zero while busy
    assign mismatch = bus.dut_y ^ (&dut_in_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dut_in_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            ffv_q    <= 1'b0;
            ffvec_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dut_in_q <= dut_in_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            ffv_q    <= ffv_d;
            ffvec_q  <= ffvec_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dut_in_d = dut_in_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        err_d    = err_q;
        ffv_d    = ffv_q;
        ffvec_d  = ffvec_q;

        case (state_q)
            IDLE: begin
                dut_in_d = '0;
                if (bus.start) begin
                    err_d   = '0;
                    pass_d  = 1'b0;
                    ffv_d   = 1'b0;
                    ffvec_d = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SETTLE_WAIT;
                end
            end
            SETTLE_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_CNT_LAST) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    if (err_q != {ERR_W{1'b1}}) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!ffv_q) begin
                        ffv_d   = 1'b1;
                        ffvec_d = dut_in_q;
                    end
                end
                // Last vector: done/pass are registered so they appear in FINISH
                if (dut_in_q == {N_IN{1'b1}}) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    dut_in_d = dut_in_q + 1'b1;
                    cnt_d    = '0;
                    state_d  = SETTLE_WAIT;
                end
            end
            FINISH: begin
                dut_in_d = '0;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.dut_in           = dut_in_q;
    assign bus.err_cnt          = err_q;
    assign bus.first_fail_valid = ffv_q;
    assign bus.first_fail_vec   = ffvec_q;

endmodule

`default_nettype wire

// File: tb/tb_and_gate_exhaustive_checker.sv
// =============================================================================
// Module  : tb_and_gate_exhaustive_checker
// Purpose : Self-checking bench for three checker configurations sharing start/reset.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_and_gate_exhaustive_checker;
    logic clk = 1'b0;
    logic rst_n;
    logic start;
    int   modeA;          // 0 = correct AND, 1 = Y stuck-at-0, 2 = Y stuck-at-1
    int   n_assert = 0;
    int   n_fail   = 0;
    bit   model_live = 1'b0;

    always #5 clk = ~clk;

    and_gate_exhaustive_checker_if #(.N_IN(3), .ERR_W(8)) ifA ();
    and_gate_exhaustive_checker_if #(.N_IN(3), .ERR_W(2)) ifB ();
    and_gate_exhaustive_checker_if #(.N_IN(2), .ERR_W(8)) ifC ();

    assign ifA.start = start;
    assign ifB.start = start;
    assign ifC.start = start;
    assign ifA.dut_y = (modeA == 0) ? (&ifA.dut_in) : (modeA == 2);
    assign ifB.dut_y = 1'b1;
    assign ifC.dut_y = &ifC.dut_in;

    and_gate_exhaustive_checker #(.N_IN(3), .SETTLE(1), .ERR_W(8)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifA.master));
    and_gate_exhaustive_checker #(.N_IN(3), .SETTLE(1), .ERR_W(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifB.master));
    and_gate_exhaustive_checker #(.N_IN(2), .SETTLE(3), .ERR_W(8)) u_c (.clk(clk), .rst_n(rst_n), .bus(ifC.master));

    typedef struct {
        bit active;
        int t;       // cycle number within the sweep, 1 = first cycle after accept
        int err;
        bit ffv;
        int ffvec;
        bit pass;
    } mstate_t;

    mstate_t mA, mB, mC;

    task automatic chk(input string nm, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_y(input int mode, input int k, input int n);
        if (mode == 1) return 1'b0;
        if (mode == 2) return 1'b1;
        return (k == (1 << n) - 1);
    endfunction

    task automatic model_exp(input mstate_t m, input int n, input int s, input int ew, input int mode,
                             output int e_in, output int e_busy, output int e_done, output int e_pass,
                             output int e_err, output int e_ffv, output int e_ffvec);
        int last, tt;
        if (!m.active) begin
            e_in = 0; e_busy = 0; e_done = 0;
            e_pass = int'(m.pass); e_err = m.err; e_ffv = int'(m.ffv); e_ffvec = m.ffvec;
        end else begin
            last = (1 << n) - 1;
            tt   = (1 << n) * (s + 1) + 1;
            e_in = (m.t - 1) / (s + 1);
            if (e_in > last) e_in = last;
            e_busy = 1;
            e_done = (m.t == tt) ? 1 : 0;
            e_err = 0; e_ffv = 0; e_ffvec = 0;
            for (int k = 0; k <= last; k++) begin
                if (((k + 1) * (s + 1) < m.t) && (model_y(mode, k, n) != (k == last))) begin
                    if (e_ffv == 0) begin
                        e_ffv = 1;
                        e_ffvec = k;
                    end
                    e_err++;
                end
            end
            if (e_err > (1 << ew) - 1) e_err = (1 << ew) - 1;
            e_pass = (m.t == tt && e_err == 0) ? 1 : 0;
        end
    endtask

    task automatic model_step(inout mstate_t m, input int n, input int s, input int ew, input int mode);
        int e_in, e_busy, e_done, e_pass, e_err, e_ffv, e_ffvec;
        if (!rst_n) begin
            m = '{default: 0};
        end else if (m.active) begin
            if (m.t == (1 << n) * (s + 1) + 1) begin
                model_exp(m, n, s, ew, mode, e_in, e_busy, e_done, e_pass, e_err, e_ffv, e_ffvec);
                m.pass = (e_pass != 0); m.err = e_err; m.ffv = (e_ffv != 0); m.ffvec = e_ffvec;
                m.active = 1'b0;
            end else begin
                m.t++;
            end
        end else if (start) begin
            m.active = 1'b1;
            m.t = 1;
        end
    endtask

    task automatic check_inst(input string nm, input mstate_t m, input int n, input int s, input int ew,
                              input int mode, input int a_in, input int a_busy, input int a_done,
                              input int a_pass, input int a_err, input int a_ffv, input int a_ffvec);
        int e_in, e_busy, e_done, e_pass, e_err, e_ffv, e_ffvec;
        model_exp(m, n, s, ew, mode, e_in, e_busy, e_done, e_pass, e_err, e_ffv, e_ffvec);
        chk({nm, ".dut_in"}, a_in, e_in);
        chk({nm, ".busy"}, a_busy, e_busy);
        chk({nm, ".done"}, a_done, e_done);
        chk({nm, ".pass"}, a_pass, e_pass);
        chk({nm, ".err_cnt"}, a_err, e_err);
        chk({nm, ".ffv"}, a_ffv, e_ffv);
        chk({nm, ".ffvec"}, a_ffvec, e_ffvec);
    endtask

    always @(posedge clk) begin
        model_step(mA, 3, 1, 8, modeA);
        model_step(mB, 3, 1, 2, 2);
        model_step(mC, 2, 3, 8, 0);
        model_live = 1'b1;
    end

    always @(negedge clk) begin
        if (model_live) begin
            check_inst("A", mA, 3, 1, 8, modeA, int'(ifA.dut_in), int'(ifA.busy), int'(ifA.done),
                       int'(ifA.pass), int'(ifA.err_cnt), int'(ifA.first_fail_valid), int'(ifA.first_fail_vec));
            check_inst("B", mB, 3, 1, 2, 2, int'(ifB.dut_in), int'(ifB.busy), int'(ifB.done),
                       int'(ifB.pass), int'(ifB.err_cnt), int'(ifB.first_fail_valid), int'(ifB.first_fail_vec));
            check_inst("C", mC, 2, 3, 8, 0, int'(ifC.dut_in), int'(ifC.busy), int'(ifC.done),
                       int'(ifC.pass), int'(ifC.err_cnt), int'(ifC.first_fail_valid), int'(ifC.first_fail_vec));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Accept edge, then observe 40 cycles; cycle 1 is the one after the accept edge
    task automatic run_sweep(input int mid_pulse, input bit hold, output int first_done, output int ndone,
                             output int c_dut_in_cnt);
        start = 1'b1;
        tick();
        first_done = 0; ndone = 0; c_dut_in_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            if (ifA.done) begin
                if (ndone == 0) first_done = c;
                ndone++;
            end
            if (ifC.busy && ifC.dut_in == 2'd2) c_dut_in_cnt++;
            start = (hold && ndone < 2) || (c == mid_pulse);
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        int fd, nd, cc;
        bit found;
        rst_n = 1'b0;
        start = 1'b0;
        modeA = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        chk("reset.A.busy", int'(ifA.busy), 0);
        chk("reset.A.err_cnt", int'(ifA.err_cnt), 0);
        tick();

        // T1 / T4 / T7: correct DUT on A and C, stuck-at-1 on 2-bit counter B
        modeA = 0;
        run_sweep(0, 1'b0, fd, nd, cc);
        chk("T1.A.done_cycle", fd, 17);
        chk("T1.A.done_count", nd, 1);
        chk("T1.A.pass", int'(ifA.pass), 1);
        chk("T1.A.err_cnt", int'(ifA.err_cnt), 0);
        chk("T1.A.ffv", int'(ifA.first_fail_valid), 0);
        chk("T4.B.err_cnt", int'(ifB.err_cnt), 3);
        chk("T4.B.ffvec", int'(ifB.first_fail_vec), 0);
        chk("T4.B.pass", int'(ifB.pass), 0);
        chk("T7.C.pass", int'(ifC.pass), 1);
        chk("T7.C.vec2_cycles", cc, 4);

        // T2: stuck-at-0
        modeA = 1;
        run_sweep(0, 1'b0, fd, nd, cc);
        chk("T2.A.err_cnt", int'(ifA.err_cnt), 1);
        chk("T2.A.ffvec", int'(ifA.first_fail_vec), 7);
        chk("T2.A.pass", int'(ifA.pass), 0);

        // T3 + T5: stuck-at-1 with a start pulse mid-sweep
        modeA = 2;
        run_sweep(5, 1'b0, fd, nd, cc);
        chk("T5.A.done_cycle", fd, 17);
        chk("T5.A.done_count", nd, 1);
        chk("T3.A.err_cnt", int'(ifA.err_cnt), 7);
        chk("T3.A.ffvec", int'(ifA.first_fail_vec), 0);
        chk("T3.A.ffv", int'(ifA.first_fail_valid), 1);

        // Held start re-triggers right after FINISH
        modeA = 0;
        run_sweep(0, 1'b1, fd, nd, cc);
        chk("hold.A.done_count", nd, 2);
        chk("hold.A.pass", int'(ifA.pass), 1);

        // T6: reset mid-sweep when dut_in == 3'b100
        modeA = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (ifA.dut_in == 3'b100) found = 1'b1;
            else tick();
        end
        chk("T6.reach_vec4", int'(found), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("T6.A.busy", int'(ifA.busy), 0);
        chk("T6.A.dut_in", int'(ifA.dut_in), 0);
        chk("T6.A.err_cnt", int'(ifA.err_cnt), 0);
        chk("T6.A.ffv", int'(ifA.first_fail_valid), 0);
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            if (ifA.done) nd++;
            tick();
        end
        chk("T6.A.no_done", nd, 0);
        modeA = 0;
        run_sweep(0, 1'b0, fd, nd, cc);
        chk("T6.A.rerun_done_cycle", fd, 17);
        chk("T6.A.rerun_pass", int'(ifA.pass), 1);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
